// File: rtl/fdp_pkg.sv
// Shared types for the fetch/decode pipeline: opcodes, ALU/immediate/result
// selectors and the decode bundle handed to execute.
package fdp_pkg;

  localparam int XLEN    = 32;
  localparam int REG_W   = 5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL,
    ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_PASSB
  } alu_ctrl_t;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_src_t;

  typedef enum logic [1:0] {RES_ALU, RES_MEM, RES_PC4} result_src_t;

  typedef struct packed {
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  imm;
    logic             reg_write;
    logic             alu_src;
    logic             mem_write;
    logic             branch;
    logic             jump;
    alu_ctrl_t        alu_ctrl;
    result_src_t      result_src;
    logic [2:0]       funct3;
    logic             illegal;
  } dec_bundle_t;

  // alt selects SUB for funct3=000 and SRA for funct3=101.
  function automatic alu_ctrl_t alu_from_funct3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/fetch_decode_pipe_if.sv
// Fetch/decode bus: ROM port, redirect input, decode bundle with valid/ready.
// Handshake: a bundle transfers on dec_valid & dec_ready; while dec_valid & !dec_ready every dec output holds.
interface fetch_decode_pipe_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) ();
  logic [DATA_WIDTH-1:0]    imem_addr;
  logic [DATA_WIDTH-1:0]    imem_rdata;
  logic                     redirect_valid;
  logic [DATA_WIDTH-1:0]    redirect_pc;
  logic                     dec_valid;
  logic                     dec_ready;
  logic [DATA_WIDTH-1:0]    dec_pc;
  logic [ADDRESS_WIDTH-1:0] rs1;
  logic [ADDRESS_WIDTH-1:0] rs2;
  logic [ADDRESS_WIDTH-1:0] rd;
  logic [DATA_WIDTH-1:0]    imm_op;
  logic                     reg_write;
  logic                     alu_src;
  logic                     mem_write;
  logic                     branch;
  logic                     jump;
  logic [3:0]               alu_ctrl;
  logic [1:0]               result_src;
  logic [2:0]               funct3;
  logic                     illegal;
  logic [DATA_WIDTH-1:0]    dbg_pc_f;
  logic                     dbg_hold_valid;

  modport master (
    output imem_addr, dec_valid, dec_pc, rs1, rs2, rd, imm_op, reg_write, alu_src,
           mem_write, branch, jump, alu_ctrl, result_src, funct3, illegal,
           dbg_pc_f, dbg_hold_valid,
    input  imem_rdata, redirect_valid, redirect_pc, dec_ready
  );

  modport slave (
    input  imem_addr, dec_valid, dec_pc, rs1, rs2, rd, imm_op, reg_write, alu_src,
           mem_write, branch, jump, alu_ctrl, result_src, funct3, illegal,
           dbg_pc_f, dbg_hold_valid,
    output imem_rdata, redirect_valid, redirect_pc, dec_ready
  );
endinterface

// File: rtl/fetch_decode_pipe_imm_extend.sv
// Immediate generator: builds the sign-extended RV32I immediate from instr[31:7].
module imm_extend
  import fdp_pkg::*;
(
  input  logic [24:0]     instr_hi,
  input  imm_src_t        imm_src,
  output logic [XLEN-1:0] imm_op
);
  // instr_hi[k] corresponds to instruction bit k+7.
  always_comb begin
    imm_op = '0;
    case (imm_src)
      IMM_I: imm_op = {{20{instr_hi[24]}}, instr_hi[24:13]};
      IMM_S: imm_op = {{20{instr_hi[24]}}, instr_hi[24:18], instr_hi[4:0]};
      IMM_B: imm_op = {{19{instr_hi[24]}}, instr_hi[24], instr_hi[0],
                       instr_hi[23:18], instr_hi[4:1], 1'b0};
      IMM_U: imm_op = {instr_hi[24:5], 12'b0};
      IMM_J: imm_op = {{11{instr_hi[24]}}, instr_hi[24], instr_hi[12:5],
                       instr_hi[13], instr_hi[23:14], 1'b0};
      default: imm_op = '0;
    endcase
  end
endmodule

// File: rtl/fetch_decode_pipe.sv
// PC owner, fetch->decode register with skid hold for stalls, and RV32I decoder.
module fetch_decode_pipe
  import fdp_pkg::*;
#(
  parameter int          ADDRESS_WIDTH = 5,
  parameter int          DATA_WIDTH    = 32,
  parameter logic [31:0] RESET_PC      = 32'h0000_0000
) (
  input logic                clk,
  input logic                rst,
  fetch_decode_pipe_if.master bus
);
  if (DATA_WIDTH != 32 || ADDRESS_WIDTH != 5) begin : g_width_check
    $error("fetch_decode_pipe supports only DATA_WIDTH=32, ADDRESS_WIDTH=5");
  end

  logic [31:0] pc_f_q, pc_f_d, pc_d_q, pc_d_d, hold_q, hold_d;
  logic        valid_d_q, valid_d_d, hold_valid_q, hold_valid_d;
  logic        advance;
  logic [31:0] instr_d, imm_raw;
  imm_src_t    imm_src;
  dec_bundle_t ctl, dec;

  assign advance       = !valid_d_q || bus.dec_ready;
  assign bus.imem_addr = bus.redirect_valid ? bus.redirect_pc : pc_f_q;
  assign instr_d       = hold_valid_q ? hold_q : bus.imem_rdata;

  always_comb begin
    pc_f_d       = pc_f_q;
    pc_d_d       = pc_d_q;
    valid_d_d    = valid_d_q;
    hold_valid_d = hold_valid_q;
    hold_d       = hold_q;
    if (bus.redirect_valid) begin
      pc_f_d       = bus.redirect_pc + 32'd4;
      pc_d_d       = bus.redirect_pc;
      valid_d_d    = 1'b1;
      hold_valid_d = 1'b0;
    end else if (advance) begin
      pc_f_d       = pc_f_q + 32'd4;
      pc_d_d       = pc_f_q;
      valid_d_d    = 1'b1;
      hold_valid_d = 1'b0;
    end else if (!hold_valid_q) begin
      // ROM has already moved on to pc_f; keep the stalled instruction.
      hold_d       = bus.imem_rdata;
      hold_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_f_q       <= RESET_PC;
      pc_d_q       <= '0;
      valid_d_q    <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
    end else begin
      pc_f_q       <= pc_f_d;
      pc_d_q       <= pc_d_d;
      valid_d_q    <= valid_d_d;
      hold_valid_q <= hold_valid_d;
      hold_q       <= hold_d;
    end
  end

  imm_extend u_imm_extend (
    .instr_hi (instr_d[31:7]),
    .imm_src  (imm_src),
    .imm_op   (imm_raw)
  );

  always_comb begin
    ctl        = '0;
    imm_src    = IMM_I;
    ctl.rs1    = instr_d[19:15];
    ctl.rs2    = instr_d[24:20];
    ctl.rd     = instr_d[11:7];
    ctl.funct3 = instr_d[14:12];
    ctl.alu_ctrl   = ALU_ADD;
    ctl.result_src = RES_ALU;
    case (instr_d[6:0])
      OPC_OP: begin
        ctl.reg_write = 1'b1;
        ctl.alu_ctrl  = alu_from_funct3(instr_d[14:12], instr_d[30]);
        ctl.illegal   = !(instr_d[31:25] == 7'h00 || instr_d[31:25] == 7'h20) ||
                        (instr_d[31:25] == 7'h20 &&
                         !(instr_d[14:12] == 3'b000 || instr_d[14:12] == 3'b101));
      end
      OPC_OP_IMM: begin
        ctl.reg_write = 1'b1;
        ctl.alu_src   = 1'b1;
        ctl.alu_ctrl  = alu_from_funct3(instr_d[14:12],
                                        instr_d[14:12] == 3'b101 && instr_d[30]);
      end
      OPC_LOAD: begin
        ctl.reg_write  = 1'b1;
        ctl.alu_src    = 1'b1;
        ctl.result_src = RES_MEM;
      end
      OPC_STORE: begin
        ctl.mem_write = 1'b1;
        ctl.alu_src   = 1'b1;
        imm_src       = IMM_S;
      end
      OPC_BRANCH: begin
        ctl.branch   = 1'b1;
        ctl.alu_ctrl = ALU_SUB;
        ctl.illegal  = instr_d[14:13] == 2'b01;
        imm_src      = IMM_B;
      end
      OPC_JAL: begin
        ctl.reg_write  = 1'b1;
        ctl.jump       = 1'b1;
        ctl.result_src = RES_PC4;
        imm_src        = IMM_J;
      end
      OPC_JALR: begin
        ctl.reg_write  = 1'b1;
        ctl.jump       = 1'b1;
        ctl.alu_src    = 1'b1;
        ctl.result_src = RES_PC4;
      end
      OPC_LUI: begin
        ctl.reg_write = 1'b1;
        ctl.alu_src   = 1'b1;
        ctl.alu_ctrl  = ALU_PASSB;
        imm_src       = IMM_U;
      end
      OPC_AUIPC: begin
        ctl.reg_write = 1'b1;
        ctl.alu_src   = 1'b1;
        imm_src       = IMM_U;
      end
      default: ctl.illegal = 1'b1;
    endcase
    if (instr_d[6:0] == OPC_STORE || instr_d[6:0] == OPC_BRANCH) ctl.rd = '0;
    if (ctl.illegal) begin
      ctl.reg_write = 1'b0;
      ctl.mem_write = 1'b0;
      ctl.branch    = 1'b0;
      ctl.jump      = 1'b0;
    end
    ctl.imm = imm_raw;
    dec     = valid_d_q ? ctl : '0;
  end

  assign bus.dec_valid      = valid_d_q;
  assign bus.dec_pc         = valid_d_q ? pc_d_q : '0;
  assign bus.rs1            = dec.rs1;
  assign bus.rs2            = dec.rs2;
  assign bus.rd             = dec.rd;
  assign bus.imm_op         = dec.imm;
  assign bus.reg_write      = dec.reg_write;
  assign bus.alu_src        = dec.alu_src;
  assign bus.mem_write      = dec.mem_write;
  assign bus.branch         = dec.branch;
  assign bus.jump           = dec.jump;
  assign bus.alu_ctrl       = dec.alu_ctrl;
  assign bus.result_src     = dec.result_src;
  assign bus.funct3         = dec.funct3;
  assign bus.illegal        = dec.illegal;
  assign bus.dbg_pc_f       = pc_f_q;
  assign bus.dbg_hold_valid = hold_valid_q;
endmodule

// File: tb/tb_fetch_decode_pipe.sv
// Directed bench for fetch_decode_pipe: ROM model, reset, decode, stall, redirect
// and mid-stall reset scenarios with hand-computed expectations.
module tb_fetch_decode_pipe;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [31:0] rom [0:255];

  fetch_decode_pipe_if bus ();

  fetch_decode_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous 1-cycle ROM
  always @(posedge clk) bus.imem_rdata <= rom[bus.imem_addr[9:2]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // addi x((k%31)+1), x0, k
  function automatic logic [31:0] addi_word(input int k);
    logic [11:0] imm;
    logic [4:0]  rdi;
    imm = 12'(k);
    rdi = 5'((k % 31) + 1);
    return {imm, 5'd0, 3'b000, rdi, 7'h13};
  endfunction

  task automatic check_addi(input string tag, input logic [31:0] pc, input int k);
    check({tag, "_pc"},  bus.dec_pc, pc);
    check({tag, "_imm"}, bus.imm_op, 32'(k));
    check({tag, "_rd"},  {27'd0, bus.rd}, 32'((k % 31) + 1));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 256; i++) rom[i] = addi_word(i);
    rom[0] = 32'h0050_0093;  // addi x1,x0,5
    rom[4] = 32'hFE20_8CE3;  // beq x1,x2,-8
    rom[5] = 32'h0000_0000;
    rom[6] = 32'h4000_1033;  // funct7=0x20 with funct3=001
    rst = 1'b1;
    bus.dec_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    repeat (3) tick();

    check("rst_valid",    {31'd0, bus.dec_valid}, 32'd0);
    check("rst_imem",     bus.imem_addr, 32'h0);
    check("rst_imm_gate", bus.imm_op, 32'h0);
    check("rst_rd_gate",  {27'd0, bus.rd}, 32'd0);

    @(negedge clk);
    rst = 1'b0;
    tick();
    check("c1_valid",   {31'd0, bus.dec_valid}, 32'd1);
    check("c1_pc",      bus.dec_pc, 32'h0);
    check("c1_rd",      {27'd0, bus.rd}, 32'd1);
    check("c1_rs1",     {27'd0, bus.rs1}, 32'd0);
    check("c1_imm",     bus.imm_op, 32'd5);
    check("c1_alusrc",  {31'd0, bus.alu_src}, 32'd1);
    check("c1_regwr",   {31'd0, bus.reg_write}, 32'd1);
    check("c1_aluctl",  {28'd0, bus.alu_ctrl}, 32'd0);
    check("c1_imem",    bus.imem_addr, 32'h4);

    tick(); check_addi("c2", 32'h4, 1);
    tick(); check_addi("c3", 32'h8, 2);
    tick(); check_addi("c4", 32'hC, 3);
    tick();
    check("br_pc",     bus.dec_pc, 32'h10);
    check("br_branch", {31'd0, bus.branch}, 32'd1);
    check("br_rs1",    {27'd0, bus.rs1}, 32'd1);
    check("br_rs2",    {27'd0, bus.rs2}, 32'd2);
    check("br_imm",    bus.imm_op, 32'hFFFF_FFF8);
    check("br_regwr",  {31'd0, bus.reg_write}, 32'd0);
    check("br_aluctl", {28'd0, bus.alu_ctrl}, 32'd1);
    check("br_rd",     {27'd0, bus.rd}, 32'd0);

    tick();
    check("ill0_pc",    bus.dec_pc, 32'h14);
    check("ill0_ill",   {31'd0, bus.illegal}, 32'd1);
    check("ill0_regwr", {31'd0, bus.reg_write}, 32'd0);
    check("ill0_valid", {31'd0, bus.dec_valid}, 32'd1);
    tick();
    check("ill1_pc",    bus.dec_pc, 32'h18);
    check("ill1_ill",   {31'd0, bus.illegal}, 32'd1);
    check("ill1_regwr", {31'd0, bus.reg_write}, 32'd0);
    check("ill1_memwr", {31'd0, bus.mem_write}, 32'd0);
    check("ill1_valid", {31'd0, bus.dec_valid}, 32'd1);

    tick(); check_addi("pre_stall", 32'h1C, 7);
    bus.dec_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      check_addi($sformatf("stall%0d", s), 32'h1C, 7);
      check($sformatf("stall%0d_hold", s), {31'd0, bus.dbg_hold_valid}, 32'd1);
    end
    bus.dec_ready = 1'b1;
    tick(); check_addi("post_stall0", 32'h20, 8);
    tick(); check_addi("post_stall1", 32'h24, 9);

    bus.dec_ready = 1'b0;
    tick(); check_addi("rd_stall", 32'h24, 9);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    #1;
    check("rd_imem", bus.imem_addr, 32'h100);
    tick();
    bus.redirect_valid = 1'b0;
    bus.dec_ready      = 1'b1;
    #1;
    check_addi("rd_tgt", 32'h100, 64);
    check("rd_hold",   {31'd0, bus.dbg_hold_valid}, 32'd0);
    check("rd_pcf0",   bus.dbg_pc_f, 32'h104);
    tick();
    check_addi("rd_next", 32'h104, 65);
    check("rd_pcf1", bus.dbg_pc_f, 32'h108);

    bus.dec_ready = 1'b0;
    tick();
    tick();
    check("rs_hold_set", {31'd0, bus.dbg_hold_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("rs_valid", {31'd0, bus.dec_valid}, 32'd0);
    check("rs_hold",  {31'd0, bus.dbg_hold_valid}, 32'd0);
    check("rs_imem",  bus.imem_addr, 32'h0);
    bus.dec_ready = 1'b1;
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("rs_first_valid", {31'd0, bus.dec_valid}, 32'd1);
    check("rs_first_pc",    bus.dec_pc, 32'h0);
    check("rs_first_imm",   bus.imm_op, 32'd5);
    check("rs_first_rd",    {27'd0, bus.rd}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_decode_pipe.md
Name: fetch_decode_pipe

Overview:
- Pipelined successor to the single-cycle control top. Owns the PC, drives a synchronous 1-cycle-latency instruction ROM, and registers fetch→decode.
- Decodes the RV32I base set (OP, OP-IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC) into a control bundle, register indices and an extended immediate.
- Hands the bundle to execute with a valid/ready handshake. Supports stall via a skid register and redirect (branch/jump taken) from execute.

Parameters:
- ADDRESS_WIDTH, 5, register-index width.
- DATA_WIDTH, 32, instruction/PC/immediate width; only 32 is supported (elaboration assertion).
- RESET_PC, 32'h0000_0000, first fetch address.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- imem_addr  out  DATA_WIDTH  ROM address; sampled by ROM at posedge
- imem_rdata  in  DATA_WIDTH  ROM data for the address sampled at the previous posedge
- redirect_valid  in  1  take new PC this cycle
- redirect_pc  in  DATA_WIDTH  target PC; word-aligned
- dec_valid  out  1  decode bundle valid
- dec_ready  in  1  execute accepts bundle
- dec_pc  out  DATA_WIDTH  PC of decoded instruction
- rs1, rs2, rd  out  ADDRESS_WIDTH each  register indices
- imm_op  out  DATA_WIDTH  sign-extended immediate
- reg_write, alu_src, mem_write, branch, jump  out  1 each  control flags
- alu_ctrl  out  4  ALU op code (package enum)
- result_src  out  2  0=ALU, 1=mem, 2=PC+4
- funct3  out  3  instr[14:12]
- illegal  out  1  unsupported opcode/funct

Behaviour:
- Reset (async, any cycle, including mid-stall or mid-redirect):
  - pc_f=RESET_PC, valid_d=0, hold_valid=0, pc_d=0.
  - All decode outputs are gated to 0 when dec_valid=0.
- advance = !valid_d | dec_ready.
- imem_addr = redirect_valid ? redirect_pc : pc_f (combinational).
- instr_d = hold_valid ? hold_q : imem_rdata.
- Priority, highest first: rst > redirect_valid > advance > stall.
  - Redirect: pc_f<=redirect_pc+4, pc_d<=redirect_pc, valid_d<=1, hold_valid<=0. This applies regardless of dec_ready; the current decode bundle is discarded even if not accepted. Penalty is 1 cycle: the target appears in decode the next cycle.
  - Advance: pc_d<=pc_f, pc_f<=pc_f+4 (mod 2^32 wrap), valid_d<=1, hold_valid<=0.
  - Stall (valid_d & !dec_ready & !redirect): pc_f and pc_d hold. On the first stall cycle (hold_valid=0), hold_q<=imem_rdata and hold_valid<=1. This is required because ROM output moves on to pc_f. Further stall cycles keep hold_q.
- Handshake: dec_valid=valid_d. All outputs stay stable while dec_valid & !dec_ready. Transfer occurs on dec_valid & dec_ready.
- Decode is combinational from instr_d; total latency from imem_addr issue is 1 cycle.
- imm_src (internal): I=0, S=1, B=2, U=3, J=4. Immediates are sign-extended from instr[31]. B/J have bit0=0. U is instr[31:12]<<12.
- Control signals:
  - OP and OP-IMM: reg_write=1. alu_ctrl comes from funct3, funct7[5] (funct7[5] only for OP, or OP-IMM shift-right). alu_src=1 for OP-IMM.
  - LOAD: alu_src=1, result_src=1.
  - STORE: mem_write=1, reg_write=0.
  - BRANCH: branch=1, alu_ctrl=SUB.
  - JAL/JALR: jump=1, result_src=2.
  - LUI: alu_ctrl=PASSB.
  - AUIPC: alu_ctrl=ADD. Execute selects PC as operand A.
- Illegal cases: unknown opcode; OP with funct7 not in {0x00, 0x20}; funct7=0x20 with funct3 not in {000, 101}; BRANCH funct3 010/011. Result: illegal=1, with reg_write, mem_write, branch, jump all forced to 0. dec_valid is still 1.
- rd forced to 0 for STORE/BRANCH. Writes to x0 are legal; execute ignores them.

Decomposition:
- Package fdp_pkg holds:
  - opcode localparams
  - alu_ctrl_t enum (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, PASSB)
  - imm_src_t enum
  - result_src_t enum
  - a packed struct for the decode bundle
- One sub-module: imm_extend (combinational, instr[31:7] + imm_src → imm_op). The main module holds the PC, pipeline/skid registers and decoder.

Test Plan:
- Reset release, ROM returns 0x00500093 (addi x1,x0,5) at 0x0 → cycle 1: dec_valid=1, dec_pc=0, rd=1, rs1=0, imm_op=5, alu_src=1, reg_write=1, alu_ctrl=ADD; imem_addr=4.
- Branch 0xFE208CE3 at pc 0x10 → branch=1, rs1=1, rs2=2, imm_op=0xFFFFFFF8, reg_write=0, alu_ctrl=SUB.
- Hold dec_ready=0 for 3 cycles while ROM output changes → dec_pc, imm_op and rd are unchanged across all 3 cycles. After release, the next bundle is pc+4 with no instruction skipped or duplicated.
- redirect_valid=1, redirect_pc=0x100 during a stall → imem_addr=0x100 that cycle; next cycle dec_pc=0x100, hold cleared, and pc_f continues 0x104, 0x108.
- instr 0x00000000 and 0x4000_0033 with funct3=001 → illegal=1, reg_write=0, mem_write=0, dec_valid=1.
- Assert rst mid-stall with hold_valid=1 → dec_valid=0 immediately (async); after release, imem_addr=RESET_PC and the first bundle is the RESET_PC instruction.
